// File: rtl/sram_cmd_master.sv
// Host-side command master: turns single SRAM/SoC-control requests into the
// byte-serial link protocol (command byte, then 4 data bytes LSB first).
module sram_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        soc_running
);

  localparam logic [1:0]  OP_WRITE  = 2'b00;
  localparam logic [1:0]  OP_READ   = 2'b01;
  localparam logic [1:0]  OP_START  = 2'b10;
  localparam logic [1:0]  OP_RESET  = 2'b11;
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, RSP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        soc_running_q, soc_running_d;
  logic        rx_ready_q;

  logic        req_fire, tx_fire, rx_fire;
  logic        skip_cmd, last_byte, tmo_hit;
  logic [15:0] tmo_inc;
  logic [7:0]  cmd_byte;

  assign req_fire  = req_valid && req_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign rx_fire   = rx_valid && rx_ready;
  assign last_byte = (byte_cnt_q == 2'd3);
  assign tmo_inc   = tmo_cnt_q + 16'd1;
  assign tmo_hit   = (state_q == RDATA) && !rx_fire && (tmo_inc == TMO_LIMIT);

  // A reset byte while stopped would be decoded by the controller as a write,
  // and a start while running is redundant, so both complete without a byte.
  assign skip_cmd = ((req_op == OP_RESET) && !soc_running_q) ||
                    ((req_op == OP_START) &&  soc_running_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      op_q          <= 2'b00;
      addr_q        <= 5'd0;
      wdata_q       <= 32'd0;
      byte_cnt_q    <= 2'd0;
      tmo_cnt_q     <= 16'd0;
      rsp_data_q    <= 32'd0;
      rsp_err_q     <= 1'b0;
      soc_running_q <= 1'b0;
      rx_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      byte_cnt_q    <= byte_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      soc_running_q <= soc_running_d;
      rx_ready_q    <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_fire) state_d = skip_cmd ? RSP : CMD;
      CMD: begin
        if (tx_fire) begin
          case (op_q)
            OP_WRITE: state_d = WDATA;
            OP_READ:  state_d = RDATA;
            default:  state_d = RSP;
          endcase
        end
      end
      WDATA: if (tx_fire && last_byte) state_d = RSP;
      RDATA: if ((rx_fire && last_byte) || tmo_hit) state_d = RSP;
      RSP:   if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: request capture, byte counting, read assembly, SoC tracking
  always_comb begin
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    soc_running_d = soc_running_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          op_d       = req_op;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          byte_cnt_d = 2'd0;
          tmo_cnt_d  = 16'd0;
          rsp_data_d = 32'd0;
          rsp_err_d  = 1'b0;
        end
      end
      CMD: begin
        // Any SRAM access leaves the SoC held in reset by the controller.
        if (tx_fire) soc_running_d = (op_q == OP_START);
      end
      WDATA: if (tx_fire) byte_cnt_d = byte_cnt_q + 2'd1;
      RDATA: begin
        if (rx_fire) begin
          rsp_data_d = {rx_data, rsp_data_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          tmo_cnt_d  = 16'd0;
        end else begin
          tmo_cnt_d = tmo_inc;
          if (tmo_hit) rsp_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_WRITE: cmd_byte = {3'b000, addr_q};
      OP_READ:  cmd_byte = {3'b001, addr_q};
      OP_START: cmd_byte = 8'h40;
      default:  cmd_byte = 8'h80;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready   = (state_q == IDLE);
    tx_valid    = (state_q == CMD) || (state_q == WDATA);
    tx_data     = 8'h00;
    if (state_q == CMD)   tx_data = cmd_byte;
    if (state_q == WDATA) tx_data = wdata_q[{byte_cnt_q, 3'b000} +: 8];
    rx_ready    = rx_ready_q;
    rsp_valid   = (state_q == RSP);
    rsp_data    = rsp_data_q;
    rsp_err     = rsp_err_q;
    soc_running = soc_running_q;
  end

endmodule

// File: tb/tb_sram_cmd_master.sv
// Directed bench for sram_cmd_master: expected link bytes and responses are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_sram_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        soc_running;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n0;
  int lat;

  logic [7:0]  tx_q[$];
  logic [32:0] rsp_q[$];

  sram_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .soc_running(soc_running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every transfer on the link and every consumed response is
  // matched against the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) chk("tx_unexpected", {25'd0, tx_data}, 33'h1_0000_0000);
        else chk("tx_byte", {25'd0, tx_data}, {25'd0, tx_q.pop_front()});
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", {rsp_err, rsp_data}, 33'h1_FFFF_FFFF);
        else chk("rsp", {rsp_err, rsp_data}, rsp_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle after acceptance; n0 holds the acceptance cycle.
  task automatic do_req(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] wd);
    int b;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    b = 0;
    while (!req_ready && b < 50) begin
      tick();
      b++;
    end
    if (!req_ready) chk("req_ready_timeout", 33'd0, 33'd1);
    tick();
    req_valid = 1'b0;
    n0 = cyc - 1;
  endtask

  task automatic wait_rsp(input string name, input int exp_lat);
    int b;
    b = 0;
    while (!rsp_valid && b < 60) begin
      tick();
      b++;
    end
    lat = cyc - n0;
    if (!rsp_valid) chk({name, "_rsp_timeout"}, 33'd0, 33'd1);
    else chk({name, "_latency"}, 33'(lat), 33'(exp_lat));
    $display("txn %s: op=%0d addr=%h wdata=%h latency=%0d rsp_data=%h rsp_err=%0d",
             name, req_op, req_addr, req_wdata, lat, rsp_data, rsp_err);
  endtask

  task automatic drive_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},   {32'd0, req_ready},   33'd1);
    chk({tag, "_tx_valid"},    {32'd0, tx_valid},    33'd0);
    chk({tag, "_tx_data"},     {25'd0, tx_data},     33'd0);
    chk({tag, "_rx_ready"},    {32'd0, rx_ready},    33'd0);
    chk({tag, "_rsp_valid"},   {32'd0, rsp_valid},   33'd0);
    chk({tag, "_rsp_data"},    {1'b0, rsp_data},     33'd0);
    chk({tag, "_rsp_err"},     {32'd0, rsp_err},     33'd0);
    chk({tag, "_soc_running"}, {32'd0, soc_running}, 33'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = 5'd0; req_wdata = 32'd0;
    rsp_ready = 1'b1; tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick();
    chk_reset_vals("por");
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("por_rx_ready_after_release", {32'd0, rx_ready}, 33'd1);

    // Write: command byte, then data LSB first; response at N+6.
    tx_q.push_back(8'h03); tx_q.push_back(8'hEF); tx_q.push_back(8'hBE);
    tx_q.push_back(8'hAD); tx_q.push_back(8'hDE);
    rsp_q.push_back({1'b0, 32'h0});
    do_req(2'b00, 5'h03, 32'hDEADBEEF);
    wait_rsp("write03", 6);
    tick();

    // Full read, with the response held back to check it stays stable.
    tx_q.push_back(8'h3F);
    rsp_q.push_back({1'b0, 32'h12345678});
    rsp_ready = 1'b0;
    do_req(2'b01, 5'h1F, 32'h0);
    tick();
    drive_rx(8'h78); drive_rx(8'h56); drive_rx(8'h34); drive_rx(8'h12);
    wait_rsp("read1F", 6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rsp_hold_valid", {32'd0, rsp_valid}, 33'd1);
      chk("rsp_hold_data", {1'b0, rsp_data}, {1'b0, 32'h12345678});
    end
    rsp_ready = 1'b1;
    tick();
    chk("rsp_released_idle", {32'd0, req_ready}, 33'd1);

    // Read with 2 bytes: 8 idle cycles after the last byte, then error.
    tx_q.push_back(8'h27);
    rsp_q.push_back({1'b1, 32'h56780000});
    do_req(2'b01, 5'h07, 32'h0);
    tick();
    drive_rx(8'h78); drive_rx(8'h56);
    wait_rsp("read07_timeout", 12);
    tick();

    // SoC reset while stopped: no byte, response next cycle.
    rsp_q.push_back({1'b0, 32'h0});
    do_req(2'b11, 5'h00, 32'h0);
    wait_rsp("soc_reset_stopped", 1);
    tick();

    tx_q.push_back(8'h40);
    rsp_q.push_back({1'b0, 32'h0});
    do_req(2'b10, 5'h00, 32'h0);
    wait_rsp("soc_start", 2);
    chk("running_after_start", {32'd0, soc_running}, 33'd1);
    tick();

    rsp_q.push_back({1'b0, 32'h0});
    do_req(2'b10, 5'h00, 32'h0);
    wait_rsp("soc_start_running", 1);
    chk("running_still", {32'd0, soc_running}, 33'd1);
    tick();

    // Write with a 10-cycle link stall on the second data byte.
    tx_q.push_back(8'h0A); tx_q.push_back(8'h44); tx_q.push_back(8'h33);
    tx_q.push_back(8'h22); tx_q.push_back(8'h11);
    rsp_q.push_back({1'b0, 32'h0});
    do_req(2'b00, 5'h0A, 32'h11223344);
    tick();
    chk("running_cleared_by_write", {32'd0, soc_running}, 33'd0);
    tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_tx_valid", {32'd0, tx_valid}, 33'd1);
      chk("stall_tx_data", {25'd0, tx_data}, 33'h33);
      tick();
    end
    tx_ready = 1'b1;
    wait_rsp("write0A_stall", 16);
    tick();

    // Reset pulse mid-read: transaction abandoned, no response expected.
    tx_q.push_back(8'h25);
    do_req(2'b01, 5'h05, 32'h0);
    tick();
    drive_rx(8'hAA);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rdata_rst");
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_rx_ready", {32'd0, rx_ready}, 33'd1);
    chk("rst_req_ready", {32'd0, req_ready}, 33'd1);
    chk("rst_no_tx", {32'd0, tx_valid}, 33'd0);
    tick();
    chk("rst_no_tx2", {32'd0, tx_valid}, 33'd0);

    // Reset while running must clear soc_running; reset op then goes direct.
    tx_q.push_back(8'h40);
    rsp_q.push_back({1'b0, 32'h0});
    do_req(2'b10, 5'h00, 32'h0);
    wait_rsp("soc_start2", 2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_clears_running", {32'd0, soc_running}, 33'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    rsp_q.push_back({1'b0, 32'h0});
    do_req(2'b11, 5'h00, 32'h0);
    wait_rsp("soc_reset_after_rst", 1);
    tick(); tick();

    chk("tx_queue_drained", 33'(tx_q.size()), 33'd0);
    chk("rsp_queue_drained", 33'(rsp_q.size()), 33'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
